// File: rtl/serial_demux8_pkg.sv
// Shared definitions for the serial_demux8 receive path.
// Holds the FSM state encoding, the ascending slot bounds and small
// helpers that derive first/last/next slot from the slot-order setting.
package serial_demux8_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam logic [2:0] SLOT_FIRST_ASC = 3'd0;
    localparam logic [2:0] SLOT_LAST_ASC  = 3'd7;

    // Slot that receives the first bit of a frame.
    function automatic logic [2:0] first_slot(input int unsigned order);
        return (order != 0) ? SLOT_LAST_ASC : SLOT_FIRST_ASC;
    endfunction

    // Slot that receives the last bit of a frame.
    function automatic logic [2:0] last_slot(input int unsigned order);
        return (order != 0) ? SLOT_FIRST_ASC : SLOT_LAST_ASC;
    endfunction

    // Slot that follows s in the given order.
    function automatic logic [2:0] step_slot(input logic [2:0] s, input int unsigned order);
        return (order != 0) ? 3'(s - 3'd1) : 3'(s + 3'd1);
    endfunction

endpackage

// File: rtl/slot_counter3.sv
// 3-bit slot counter for serial_demux8.
// Ports:
//   clk, rst  clock and asynchronous active-high reset (reset -> first slot)
//   load      return to the first slot
//   step      advance one slot in the configured order
//   slot      current slot index
// load and step together land on the slot after the first, which is what a
// resync needs (the first bit is written in the same edge).
module slot_counter3
    import serial_demux8_pkg::*;
#(
    parameter int unsigned ORDER = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    output logic [2:0] slot
);

    localparam logic [2:0] FIRST       = first_slot(ORDER);
    localparam logic [2:0] FIRST_NEXT  = step_slot(FIRST, ORDER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= FIRST;
        end else if (load) begin
            slot <= step ? FIRST_NEXT : FIRST;
        end else if (step) begin
            slot <= step_slot(slot, ORDER);
        end
    end

endmodule

// File: rtl/serial_demux8.sv
// Serial 1-to-8 time-division demultiplexer (receive end of an 8-slot lane).
// Collects valid bits into a shadow register and publishes a complete
// frame as one registered word.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   D, V, F   serial bit, bit-valid, frame-start (F qualified by V)
//   Y         last complete frame, Y[k] = bit for slot k
//   Q         one-cycle pulse: Y just loaded
//   S         slot the next valid bit goes to
//   ERR       one-cycle pulse: mid-frame F, partial frame dropped
module serial_demux8
    import serial_demux8_pkg::*;
#(
    parameter int unsigned ORDER = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       D,
    input  logic       V,
    input  logic       F,
    output logic [7:0] Y,
    output logic       Q,
    output logic [2:0] S,
    output logic       ERR
);

    localparam logic [2:0] FIRST = first_slot(ORDER);
    localparam logic [2:0] LAST  = last_slot(ORDER);

    state_t     state;
    state_t     next_state;
    logic [7:0] shadow;
    logic [7:0] shadow_next;
    logic [7:0] y_next;
    logic       q_next;
    logic       err_next;
    logic       cnt_load;
    logic       cnt_step;

    slot_counter3 #(
        .ORDER(ORDER)
    ) u_slot (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .step (cnt_step),
        .slot (S)
    );

    // Next-state and datapath control.
    always_comb begin
        next_state  = state;
        shadow_next = shadow;
        y_next      = Y;
        q_next      = 1'b0;
        err_next    = 1'b0;
        cnt_load    = 1'b0;
        cnt_step    = 1'b0;
        case (state)
            IDLE: begin
                // Stray bits without F are dropped silently.
                if (V && F) begin
                    shadow_next        = 8'h00;
                    shadow_next[FIRST] = D;
                    cnt_step           = 1'b1;
                    next_state         = FILL;
                end
            end
            FILL: begin
                if (V) begin
                    if (F) begin
                        // Resync: drop partial frame, restart with this bit.
                        err_next           = 1'b1;
                        shadow_next        = 8'h00;
                        shadow_next[FIRST] = D;
                        cnt_load           = 1'b1;
                        cnt_step           = 1'b1;
                    end else if (S == LAST) begin
                        // Last bit bypasses shadow straight into Y.
                        y_next      = shadow;
                        y_next[S]   = D;
                        q_next      = 1'b1;
                        shadow_next = 8'h00;
                        cnt_load    = 1'b1;
                        next_state  = IDLE;
                    end else begin
                        shadow_next[S] = D;
                        cnt_step       = 1'b1;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, shadow and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            shadow <= 8'h00;
            Y      <= 8'h00;
            Q      <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            state  <= next_state;
            shadow <= shadow_next;
            Y      <= y_next;
            Q      <= q_next;
            ERR    <= err_next;
        end
    end

endmodule

// File: doc/serial_demux8.md
Name: serial_demux8

Overview:
- Sequential 1-to-8 time-division demultiplexer: the receive end of an 8-slot serial lane whose transmit end uses the 8:1 mux (select S2..S0 stepping 0..7).
- Takes one bit per valid cycle, steers it into slot 0..7 via an internal slot counter, and publishes all 8 slots as one registered word when the frame is complete.
- Sits between the serial lane and parallel consumer logic.

Parameters:
- ORDER, 0, slot order within a frame: 0 = ascending (first bit goes to Y[0], last to Y[7]); 1 = descending (first bit goes to Y[7], last to Y[0]).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- D    input  1  serial data bit.
- V    input  1  D is valid this cycle.
- F    input  1  frame start; meaningful only when V=1; marks D as the first slot of a frame.
- Y    output 8  registered parallel word; Y[k] = bit received for slot k.
- Q    output 1  one-cycle pulse: Y has just been updated with a complete frame.
- S    output 3  slot index the next valid bit will be written to.
- ERR  output 1  one-cycle pulse: F arrived mid-frame and the partial frame was discarded.

Behaviour:
- Reset is asynchronous, active-high: state=IDLE, Y=8'h00, Q=0, ERR=0, S=first slot (0 if ORDER=0, 7 if ORDER=1), shadow register=8'h00.
- Storage:
  - 8-bit shadow register collects bits during a frame.
  - Y is loaded only from a complete frame and never shows a partial frame.
- States:
  - IDLE
    - V=1, F=1: write D to shadow[first slot], S steps to the next slot, go to FILL.
    - V=1, F=0: bit is dropped; nothing changes and no ERR.
    - V=0: hold.
  - FILL
    - V=0: hold; the frame may stall any number of cycles.
    - V=1, F=0, S not last: write D to shadow[S], S steps by +1 (ORDER=0) or -1 (ORDER=1).
    - V=1, F=0, S = last slot (7 for ORDER=0, 0 for ORDER=1):
      - Y <= shadow with D merged into slot S, in the same edge.
      - Q=1 for the next cycle only.
      - S returns to the first slot; go to IDLE.
    - V=1, F=1 (resync):
      - ERR=1 for one cycle.
      - Shadow cleared to 8'h00, then D written to the first slot.
      - S = first slot stepped once; stay in FILL.
      - Y unchanged.
- Latency: Y and Q are valid in the cycle after the edge that samples the last bit; 8 valid bits → 1 word.
- Back-to-back frames: the cycle after the last bit may carry V=1, F=1. It is accepted from IDLE with no bubble, so Q for the old frame and acceptance of the new first bit coincide.
- Q and ERR are never asserted together.
- Shadow is cleared when a frame completes, so no stale bits carry into the next frame.
- S counter is 3 bits and never wraps silently; it is reset to the first slot on completion or resync.
- rst asserted mid-frame: the partial frame is lost; Y returns to 8'h00 immediately (asynchronous); no Q or ERR.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=1'b0, FILL=1'b1;
  - slot constants SLOT_FIRST_ASC=3'd0, SLOT_LAST_ASC=3'd7.
- One sub-module is natural: slot_counter3, a 3-bit up/down counter with async reset, load-to-first and step-enable, direction set by ORDER.
- Shadow/Y registers and the FSM stay in serial_demux8.

Test Plan:
- ORDER=0; reset, then 8 consecutive V=1 cycles with F=1 on the first, D = 1,0,1,1,0,0,1,0 → Q pulses one cycle after the 8th bit, Y=8'h4D, S=0, ERR=0.
- ORDER=1; same stimulus → Y=8'hB2, Q pulse, S=7 afterwards.
- ORDER=0; frame of D=1 on all 8 bits with V deasserted for 3 cycles after bit 4 → Y=8'hFF, Q exactly one cycle after the 8th valid bit, Y held at the prior value during the stall.
- ORDER=0; 5 bits of D=1 (F on first), then V=1, F=1, D=0 followed by 7 bits of D=0 → ERR pulse on resync, no Q for the partial frame, then Q with Y=8'h00.
- V=1, F=0 bits in IDLE (D=1 x4), then a valid frame 8'hA5 → stray bits ignored, Y=8'hA5; two back-to-back frames 8'hA5 then 8'h3C → Q pulses 8 cycles apart, Y sequence A5, 3C.
- rst asserted at bit 6 of a frame after a prior Y=8'h4D → Y=8'h00 immediately, S=0, no Q; next full frame 8'h81 → Y=8'h81.
